// File: rtl/stream_arbiter_pkg.sv
// Shared definitions for the stream arbiter: state encoding, tag prefix, width helper.
// The optional tag byte (STREAM_ARBITER_TAG_EN) uses ST_TAG and TAG_PREFIX.
package stream_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_TAG  = 2'd2
    } state_t;

    localparam logic [3:0] TAG_PREFIX = 4'hF;

    // Ceiling log2, never less than one bit so a width is always legal.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/stream_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request after the pointer, modulo N.
// Reusable by any block sharing a resource among N requesters.
module rr_pick
    import stream_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] pointer,
    output logic             any,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        any    = 1'b0;
        onehot = '0;
        index  = '0;
        cand   = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(pointer) + k) % N);
            if (!any && req[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                index        = cand;
            end
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// Round-robin arbiter sharing one valid/ready byte sink among N sources, bounded bursts.
// Define STREAM_ARBITER_TAG_EN to emit a {4'hF, index} tag byte before each grant's data.
module stream_arbiter
    import stream_arbiter_pkg::*;
#(
    parameter int N         = 4,
    parameter int BURST_LEN = 16
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic [8*N-1:0] req_dat,
    input  logic [N-1:0]   req_val,
    output logic [N-1:0]   req_rdy,
    output logic [7:0]     out_dat,
    output logic           out_val,
    input  logic           out_rdy,
    output logic [N-1:0]   grant,
    output logic           busy
);

    localparam int IDX_W = clog2(N);
    localparam int CNT_W = clog2(BURST_LEN + 1);

    state_t           state, state_nxt;
    logic [N-1:0]     grant_nxt;
    logic [IDX_W-1:0] pointer, pointer_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [CNT_W-1:0] count_inc;

    logic             pick_any;
    logic [N-1:0]     pick_onehot;
    logic [IDX_W-1:0] pick_index;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req_val),
        .pointer (pointer),
        .any     (pick_any),
        .onehot  (pick_onehot),
        .index   (pick_index)
    );

    assign busy      = (state != ST_IDLE);
    assign count_inc = count + CNT_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            grant   <= '0;
            pointer <= IDX_W'(N - 1);
            idx     <= '0;
            count   <= '0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            pointer <= pointer_nxt;
            idx     <= idx_nxt;
            count   <= count_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        pointer_nxt = pointer;
        idx_nxt     = idx;
        count_nxt   = count;
        out_dat     = 8'h00;
        out_val     = 1'b0;
        req_rdy     = '0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_nxt = pick_onehot;
                    idx_nxt   = pick_index;
                    count_nxt = '0;
`ifdef STREAM_ARBITER_TAG_EN
                    state_nxt = ST_TAG;
`else
                    state_nxt = ST_PASS;
`endif
                end
            end
`ifdef STREAM_ARBITER_TAG_EN
            ST_TAG: begin
                out_dat = {TAG_PREFIX, 4'(idx)};
                out_val = 1'b1;
                if (out_rdy) state_nxt = ST_PASS;
            end
`endif
            ST_PASS: begin
                out_dat      = req_dat[8*idx +: 8];
                out_val      = req_val[idx];
                req_rdy[idx] = out_rdy & req_val[idx];
                // Burst limit takes priority; a dry source also releases the grant.
                if (req_val[idx] && out_rdy) begin
                    count_nxt = count_inc;
                    if (count_inc == CNT_W'(BURST_LEN)) begin
                        state_nxt   = ST_IDLE;
                        pointer_nxt = idx;
                        grant_nxt   = '0;
                    end
                end else if (!req_val[idx]) begin
                    state_nxt   = ST_IDLE;
                    pointer_nxt = idx;
                    grant_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_stream_arbiter.sv
// Self-checking bench for stream_arbiter (N=4, BURST_LEN=3) against an owner/queue reference model.
// Honours STREAM_ARBITER_TAG_EN when the design is built with it.
module tb_stream_arbiter;

    localparam int N         = 4;
    localparam int BURST_LEN = 3;
`ifdef STREAM_ARBITER_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset_n;
    logic [8*N-1:0] req_dat;
    logic [N-1:0]   req_val;
    logic [N-1:0]   req_rdy;
    logic [7:0]     out_dat;
    logic           out_val;
    logic           out_rdy;
    logic [N-1:0]   grant;
    logic           busy;

    stream_arbiter #(.N(N), .BURST_LEN(BURST_LEN)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req_dat (req_dat),
        .req_val (req_val),
        .req_rdy (req_rdy),
        .out_dat (out_dat),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .grant   (grant),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Source-side stimulus: bytes still to send, and whether a byte is being offered.
    logic [7:0] srcq [N][$];
    logic [7:0] got_bytes [N][$];
    int         order [$];
    bit         holding [N];
    int         pres_pct = 100;
    int         rdy_mode = 0;
    logic [7:0] obs_dat;
    logic       obs_val;

    // Reference model: who owns the sink (-1 = nobody), last owner, bytes this grant.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_sent  = 0;
    bit m_tag   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (!holding[i] && srcq[i].size() > 0 && $urandom_range(99) < pres_pct)
                holding[i] = 1'b1;
            req_val[i]       = holding[i];
            req_dat[8*i +: 8] = holding[i] ? srcq[i][0] : 8'($urandom);
        end
        if (rdy_mode == 0)      out_rdy = 1'b1;
        else if (rdy_mode == 2) out_rdy = 1'b0;
        else                    out_rdy = ($urandom_range(99) < 70);
    endtask

    task automatic model_cycle();
        logic          e_val;
        logic [7:0]    e_dat;
        logic [N-1:0]  e_rdy;
        logic [N-1:0]  e_grant;
        logic          e_busy;
        logic [7:0]    tmp;
        bit            found;
        int            c;
        e_val   = 1'b0;
        e_dat   = 8'h00;
        e_rdy   = '0;
        e_grant = '0;
        e_busy  = (m_owner >= 0);
        if (m_owner >= 0) e_grant[m_owner] = 1'b1;
        if (m_owner >= 0 && m_tag) begin
            e_val = 1'b1;
            e_dat = {4'hF, 4'(m_owner)};
        end else if (m_owner >= 0) begin
            e_val          = req_val[m_owner];
            e_dat          = req_dat[8*m_owner +: 8];
            e_rdy[m_owner] = out_rdy & req_val[m_owner];
        end
        check_eq("out_val", 32'(out_val), 32'(e_val));
        check_eq("req_rdy", 32'(req_rdy), 32'(e_rdy));
        check_eq("grant", 32'(grant), 32'(e_grant));
        check_eq("busy", 32'(busy), 32'(e_busy));
        if (e_val) check_eq("out_dat", 32'(out_dat), 32'(e_dat));
        obs_dat = out_dat;
        obs_val = out_val;
        for (int i = 0; i < N; i++) begin
            if (req_rdy[i] && req_val[i] && out_val && out_rdy) begin
                got_bytes[i].push_back(out_dat);
                order.push_back(i);
            end
            if (e_rdy[i]) begin
                tmp        = srcq[i].pop_front();
                holding[i] = 1'b0;
            end
        end
        if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!found && req_val[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                end
            end
            m_sent = 0;
            m_tag  = found && TAG_EN;
        end else if (m_tag) begin
            if (out_rdy) m_tag = 1'b0;
        end else if (e_val && out_rdy) begin
            m_sent++;
            if (m_sent == BURST_LEN) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end else if (!req_val[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end
        if (tmp === 8'hxx) tmp = 8'h00;
    endtask

    // One clock: drive just after the edge, check at the falling edge.
    task automatic step();
        drive_inputs();
        @(negedge clock);
        model_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while ((!queues_empty() || m_owner >= 0) && cyc < budget) begin
            step();
            cyc++;
        end
        check_eq(tag, 32'(cyc < budget), 32'd1);
    endtask

    task automatic clear_logs();
        order.delete();
        for (int i = 0; i < N; i++) got_bytes[i].delete();
    endtask

    initial begin
        int lowest;
        int guard;
        reset_n = 1'b0;
        req_val = '0;
        req_dat = '0;
        out_rdy = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("rst_out_val", 32'(out_val), 32'd0);
        check_eq("rst_req_rdy", 32'(req_rdy), 32'd0);
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_out_dat", 32'(out_dat), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Single source streaming five bytes.
        clear_logs();
        for (int b = 0; b < 5; b++) srcq[2].push_back(8'h41 + 8'(b));
        pres_pct = 100;
        rdy_mode = 0;
        drain("single_drain", 200);
        check_eq("single_count", 32'(got_bytes[2].size()), 32'd5);
        for (int k = 0; k < 5; k++)
            check_eq("single_byte", (k < got_bytes[2].size()) ? 32'(got_bytes[2][k]) : 32'hFFFF,
                     32'h41 + 32'(k));

        // Two continuously valid sources alternate in bursts of BURST_LEN.
        clear_logs();
        for (int b = 0; b < 9; b++) begin
            srcq[0].push_back(8'h00 + 8'(b));
            srcq[1].push_back(8'h80 + 8'(b));
        end
        drain("fair_drain", 300);
        check_eq("fair_len", 32'(order.size()), 32'd18);
        for (int k = 0; k < 18; k++)
            check_eq("fair_order", (k < order.size()) ? 32'(order[k]) : 32'hFFFF,
                     32'((k / BURST_LEN) % 2));

        // Backpressure mid-burst holds data steady.
        clear_logs();
        for (int b = 0; b < 6; b++) srcq[0].push_back(8'h10 + 8'(b));
        repeat (2 + int'(TAG_EN)) step();
        rdy_mode = 2;
        repeat (10) begin
            step();
            check_eq("bp_dat", 32'(obs_dat), 32'h11);
            check_eq("bp_val", 32'(obs_val), 32'd1);
        end
        rdy_mode = 0;
        drain("bp_drain", 200);
        check_eq("bp_count", 32'(got_bytes[0].size()), 32'd6);

        // Wrap-around: after serving source 3, source 0 beats source 3.
        srcq[3].push_back(8'h33);
        drain("wrap_pre", 100);
        srcq[0].push_back(8'hA0);
        srcq[3].push_back(8'hA3);
        step();
        check_eq("wrap_grant", 32'(grant), 32'h1);
        drain("wrap_drain", 100);

`ifdef STREAM_ARBITER_TAG_EN
        srcq[1].push_back(8'h55);
        rdy_mode = 2;
        step();
        repeat (4) begin
            step();
            check_eq("tag_dat", 32'(obs_dat), 32'hF1);
            check_eq("tag_val", 32'(obs_val), 32'd1);
        end
        rdy_mode = 0;
        step();
        step();
        check_eq("tag_data", 32'(obs_dat), 32'h55);
        drain("tag_drain", 100);
`endif

        // Asynchronous reset while a byte is on offer.
        for (int b = 0; b < 5; b++) begin
            srcq[1].push_back(8'hC0 + 8'(b));
            srcq[3].push_back(8'hE0 + 8'(b));
        end
        guard = 0;
        while (!(m_owner >= 0 && !m_tag && holding[m_owner]) && guard < 200) begin
            step();
            guard++;
        end
        check_eq("rst_reach_pass", 32'(guard < 200), 32'd1);
        pres_pct = 0;
        rdy_mode = 2;
        drive_inputs();
        #1;
        check_eq("rst_pre_val", 32'(out_val), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("arst_out_val", 32'(out_val), 32'd0);
        check_eq("arst_req_rdy", 32'(req_rdy), 32'd0);
        check_eq("arst_grant", 32'(grant), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        m_owner = -1;
        m_last  = N - 1;
        m_tag   = 1'b0;
        @(posedge clock);
        #1;
        lowest = -1;
        for (int i = N - 1; i >= 0; i--) if (holding[i]) lowest = i;
        reset_n = 1'b1;
        step();
        check_eq("arst_first_grant", 32'(grant), (lowest >= 0) ? (32'd1 << lowest) : 32'd0);
        pres_pct = 100;
        rdy_mode = 0;
        drain("arst_drain", 300);

        // Randomized traffic with random backpressure.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) begin
                int len;
                len = $urandom_range(8);
                for (int b = 0; b < len; b++) srcq[i].push_back(8'($urandom));
            end
            pres_pct = 60;
            rdy_mode = 1;
            drain("rand_drain", 2000);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
